// File: rtl/axi_r_responder_if.sv
// Bus bundle for the AXI read responder: AR FIFO head, memory read port and R channel.
// The slave modport is the responder's view; master is the view of its surroundings.
interface axi_r_responder_if #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 4,
   parameter int SIZE_WIDTH = 3
);
   logic [ID_WIDTH-1:0]   front_ARID;
   logic [ADDR_WIDTH-1:0] front_ARADDR;
   logic [LEN_WIDTH-1:0]  front_ARLEN;
   logic [SIZE_WIDTH-1:0] front_ARSIZE;
   logic [1:0]            front_ARBURST;
   logic                  empty;
   logic                  pop;

   logic                  mem_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic [ID_WIDTH-1:0]   RID;
   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RLAST;
   logic                  RVALID;
   logic                  RREADY;

   modport slave (
      input  front_ARID, front_ARADDR, front_ARLEN, front_ARSIZE, front_ARBURST, empty,
      input  mem_rdata, RREADY,
      output pop, mem_en, mem_addr,
      output RID, RDATA, RRESP, RLAST, RVALID
   );

   modport master (
      output front_ARID, front_ARADDR, front_ARLEN, front_ARSIZE, front_ARBURST, empty,
      output mem_rdata, RREADY,
      input  pop, mem_en, mem_addr,
      input  RID, RDATA, RRESP, RLAST, RVALID
   );
endinterface

// File: rtl/axi_r_responder.sv
// Slave-side AXI read responder: pops one AR request, walks the FIXED/INCR/WRAP burst
// with one synchronous memory read per beat, and returns each beat on the R channel.
module axi_r_responder #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 4,
   parameter int SIZE_WIDTH = 3
) (
   input  logic             ACLK,
   input  logic             ARESET,
   axi_r_responder_if.slave bus
);

   localparam int         MAX_SIZE    = $clog2(DATA_WIDTH / 8);
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, REQ, CAP, SEND} state_t;

   state_t                state_q, state_d;

   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  beat_q;
   logic [SIZE_WIDTH-1:0] size_q;
   logic                  fixed_q;
   logic                  wrap_q;
   logic                  err_q;

   logic [DATA_WIDTH-1:0] rdata_p0;
   logic                  vld_p0;

   logic                  pop_c;
   logic                  mem_en_c;
   logic                  load;
   logic                  capture;
   logic                  accept;
   logic                  advance;
   logic                  last_beat;

   // WRAP is only legal for 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [LEN_WIDTH-1:0] len);
      logic [LEN_WIDTH-1:0] len_inc;
      len_inc = len + LEN_WIDTH'(1);
      return (len != '0) && ((len & len_inc) == '0) && (int'(len) <= 15);
   endfunction

   function automatic logic size_too_big(input logic [SIZE_WIDTH-1:0] size);
      return int'(size) > MAX_SIZE;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] next_addr(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [LEN_WIDTH-1:0]  len,
      input logic [SIZE_WIDTH-1:0] size,
      input logic                  fixed,
      input logic                  wrap
   );
      logic [ADDR_WIDTH-1:0] step;
      logic [ADDR_WIDTH-1:0] inc;
      logic [ADDR_WIDTH-1:0] total;
      logic [ADDR_WIDTH-1:0] mask;
      step  = ADDR_WIDTH'(1) << size;
      inc   = addr + step;
      total = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
      mask  = total - ADDR_WIDTH'(1);
      if (fixed)
         return addr;
      else if (wrap)
         return (addr & ~mask) | (inc & mask);
      else
         return inc;
   endfunction

   assign last_beat = (beat_q == len_q);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pop_c    = 1'b0;
      mem_en_c = 1'b0;
      load     = 1'b0;
      capture  = 1'b0;
      accept   = 1'b0;
      advance  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.empty && !ARESET) begin
               pop_c   = 1'b1;
               load    = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            mem_en_c = 1'b1;
            state_d  = CAP;
         end
         CAP: begin
            capture = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (bus.RREADY) begin
               accept = 1'b1;
               if (last_beat) begin
                  state_d = IDLE;
               end else begin
                  advance = 1'b1;
                  state_d = REQ;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Burst context, latched on pop and stepped after each accepted non-final beat.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         size_q  <= '0;
         fixed_q <= 1'b0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (load) begin
         id_q    <= bus.front_ARID;
         addr_q  <= bus.front_ARADDR;
         len_q   <= bus.front_ARLEN;
         beat_q  <= '0;
         size_q  <= bus.front_ARSIZE;
         fixed_q <= (bus.front_ARBURST == BURST_FIXED);
         wrap_q  <= (bus.front_ARBURST == BURST_WRAP) && wrap_len_ok(bus.front_ARLEN);
         err_q   <= (bus.front_ARBURST == BURST_RSVD) ||
                    size_too_big(bus.front_ARSIZE) ||
                    ((bus.front_ARBURST == BURST_WRAP) && !wrap_len_ok(bus.front_ARLEN));
      end else if (advance) begin
         addr_q  <= next_addr(addr_q, len_q, size_q, fixed_q, wrap_q);
         beat_q  <= beat_q + LEN_WIDTH'(1);
      end
   end

   // Stage p0: memory data captured one cycle after the read strobe, held until accepted.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rdata_p0 <= '0;
         vld_p0   <= 1'b0;
      end else if (capture) begin
         rdata_p0 <= bus.mem_rdata;
         vld_p0   <= 1'b1;
      end else if (accept) begin
         vld_p0   <= 1'b0;
      end
   end

   assign bus.pop      = pop_c;
   assign bus.mem_en   = mem_en_c;
   assign bus.mem_addr = addr_q;
   assign bus.RID      = id_q;
   assign bus.RDATA    = rdata_p0;
   assign bus.RVALID   = vld_p0;
   assign bus.RRESP    = (vld_p0 && err_q) ? RESP_SLVERR : RESP_OKAY;
   assign bus.RLAST    = vld_p0 && last_beat;

endmodule

// File: tb/tb_axi_r_responder.sv
// Randomised and directed bench for axi_r_responder with a queue-based burst model
// and a per-cycle compare process on the falling clock edge.
module tb_axi_r_responder;
   localparam int IDW = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LW  = 4;
   localparam int SW  = 3;

   logic ACLK = 1'b0;
   logic ARESET = 1'b0;
   always #5 ACLK = ~ACLK;

   axi_r_responder_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .LEN_WIDTH(LW), .SIZE_WIDTH(SW)) bus ();

   axi_r_responder #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .LEN_WIDTH(LW), .SIZE_WIDTH(SW)) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   ar_t   arq[$];
   beat_t rq[$];
   beat_t scratch[$];
   int    pop_log[$];
   int    rv_log[$];

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int next_en = -1;
   int rv_from = -1;
   int cur_beat = 0;
   int rmode = 0;
   int low_cnt = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic ar_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
      ar_t a;
      a.id = id; a.addr = addr; a.len = len; a.size = size; a.burst = burst;
      return a;
   endfunction

   // Expected beats of one burst, from plain byte arithmetic over a 4 GiB address space.
   function automatic void model_beats(input ar_t a);
      longint bytes = longint'(1) << a.size;
      int     n     = int'(a.len) + 1;
      bit     wrap_ok = (a.burst == 2'b10) && (n == 2 || n == 4 || n == 8 || n == 16);
      bit     err   = (a.burst == 2'b11) || (bytes > DW / 8) || ((a.burst == 2'b10) && !wrap_ok);
      longint total = longint'(n) * bytes;
      longint cur   = longint'(a.addr);
      longint base;
      scratch.delete();
      for (int i = 0; i < n; i++) begin
         beat_t b;
         b.addr = cur[31:0];
         b.id   = a.id;
         b.resp = err ? 2'b10 : 2'b00;
         b.last = (i == n - 1);
         scratch.push_back(b);
         if (a.burst != 2'b00) begin
            if (wrap_ok) begin
               base = cur - (cur % total);
               cur  = base + ((cur - base + bytes) % total);
            end else begin
               cur = (cur + bytes) % (longint'(1) << 32);
            end
         end
      end
   endfunction

   task automatic pin(input string name, input ar_t a, input int n, input logic [1:0] resp,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] e[4];
      e = '{e0, e1, e2, e3};
      model_beats(a);
      chk({name, "_nbeats"}, 64'(scratch.size()), 64'(n));
      for (int i = 0; i < n && i < scratch.size(); i++) begin
         chk({name, "_addr"}, 64'(scratch[i].addr), 64'(e[i]));
         chk({name, "_resp"}, 64'(scratch[i].resp), 64'(resp));
         chk({name, "_last"}, 64'(scratch[i].last), 64'(i == n - 1));
      end
   endtask

   // AR FIFO, memory and RREADY driver; inputs change 1 ns after the rising edge.
   initial begin : driver
      logic        en_s, pop_s, rv_s, rdy_s;
      logic [31:0] a_s;
      bus.empty = 1'b1;
      bus.front_ARID = '0; bus.front_ARADDR = '0; bus.front_ARLEN = '0;
      bus.front_ARSIZE = '0; bus.front_ARBURST = '0;
      bus.mem_rdata = '0;
      bus.RREADY = 1'b0;
      forever begin
         @(negedge ACLK);
         en_s = bus.mem_en; a_s = bus.mem_addr; pop_s = bus.pop;
         rv_s = bus.RVALID; rdy_s = bus.RREADY;
         @(posedge ACLK);
         #1;
         if (pop_s && arq.size() > 0) arq.delete(0);
         bus.mem_rdata = en_s ? memf(a_s) : $urandom();
         if (rv_s && !rdy_s && rmode == 2) low_cnt++;
         case (rmode)
            0: bus.RREADY = 1'b1;
            1: bus.RREADY = ($urandom_range(0, 3) != 0);
            2: bus.RREADY = !(cur_beat == 1 && low_cnt < 5);
            default: bus.RREADY = 1'b0;
         endcase
         if (arq.size() > 0) begin
            bus.empty         = 1'b0;
            bus.front_ARID    = arq[0].id;
            bus.front_ARADDR  = arq[0].addr;
            bus.front_ARLEN   = arq[0].len;
            bus.front_ARSIZE  = arq[0].size;
            bus.front_ARBURST = arq[0].burst;
         end else begin
            bus.empty = 1'b1;
         end
      end
   end

   initial begin : compare
      logic        hold, prev_rv;
      logic [3:0]  p_id;
      logic [31:0] p_data;
      logic [1:0]  p_resp;
      logic        p_last;
      logic        exp_pop, exp_rv, exp_en;
      ar_t         a;
      hold = 1'b0; prev_rv = 1'b0;
      p_id = '0; p_data = '0; p_resp = '0; p_last = 1'b0;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            chk("rst_RVALID", 64'(bus.RVALID), 64'd0);
            chk("rst_RLAST", 64'(bus.RLAST), 64'd0);
            chk("rst_RRESP", 64'(bus.RRESP), 64'd0);
            chk("rst_RID", 64'(bus.RID), 64'd0);
            chk("rst_RDATA", 64'(bus.RDATA), 64'd0);
            chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
            chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
            chk("rst_pop", 64'(bus.pop), 64'd0);
            rq.delete();
            next_en = -1; rv_from = -1; cur_beat = 0;
            hold = 1'b0; prev_rv = 1'b0;
         end else begin
            exp_pop = !bus.empty && (rq.size() == 0);
            chk("pop", 64'(bus.pop), 64'(exp_pop));
            if (exp_pop) begin
               a = mk(bus.front_ARID, bus.front_ARADDR, bus.front_ARLEN,
                      bus.front_ARSIZE, bus.front_ARBURST);
               model_beats(a);
               foreach (scratch[i]) rq.push_back(scratch[i]);
               next_en = cyc + 1;
               cur_beat = 0;
               pop_log.push_back(cyc);
            end
            exp_en = (cyc == next_en);
            chk("mem_en", 64'(bus.mem_en), 64'(exp_en));
            if (exp_en) begin
               if (rq.size() > 0) chk("mem_addr", 64'(bus.mem_addr), 64'(rq[0].addr));
               rv_from = cyc + 2;
               next_en = -1;
            end
            exp_rv = (rv_from >= 0) && (cyc >= rv_from);
            chk("RVALID", 64'(bus.RVALID), 64'(exp_rv));
            if (bus.RVALID && !prev_rv) rv_log.push_back(cyc);
            if (hold) begin
               chk("hold_RID", 64'(bus.RID), 64'(p_id));
               chk("hold_RDATA", 64'(bus.RDATA), 64'(p_data));
               chk("hold_RRESP", 64'(bus.RRESP), 64'(p_resp));
               chk("hold_RLAST", 64'(bus.RLAST), 64'(p_last));
            end
            if (exp_rv && bus.RREADY && rq.size() > 0) begin
               chk("RID", 64'(bus.RID), 64'(rq[0].id));
               chk("RDATA", 64'(bus.RDATA), 64'(memf(rq[0].addr)));
               chk("RRESP", 64'(bus.RRESP), 64'(rq[0].resp));
               chk("RLAST", 64'(bus.RLAST), 64'(rq[0].last));
               rq.delete(0);
               rv_from = -1;
               cur_beat++;
               if (rq.size() > 0) next_en = cyc + 1;
            end
            hold = bus.RVALID && !bus.RREADY;
            prev_rv = bus.RVALID;
            p_id = bus.RID; p_data = bus.RDATA; p_resp = bus.RRESP; p_last = bus.RLAST;
         end
         cyc++;
      end
   end

   task automatic wait_idle(input int bound);
      int n = 0;
      do begin
         @(posedge ACLK);
         #2;
         n++;
      end while (!(arq.size() == 0 && rq.size() == 0 && bus.empty) && n < bound);
      chk("idle_timeout", 64'(n < bound), 64'd1);
      repeat (2) @(posedge ACLK);
      #2;
   endtask

   initial begin : main
      int n;
      #1 ARESET = 1'b1;

      pin("pin_incr", mk(5, 32'h100, 3, 2, 2'b01), 4, 2'b00, 32'h100, 32'h104, 32'h108, 32'h10C);
      pin("pin_wrap", mk(1, 32'h108, 3, 2, 2'b10), 4, 2'b00, 32'h108, 32'h10C, 32'h100, 32'h104);
      pin("pin_fixed", mk(2, 32'h40, 2, 2, 2'b00), 3, 2'b00, 32'h40, 32'h40, 32'h40, 32'h0);
      pin("pin_top", mk(3, 32'hFFFF_FFFC, 1, 2, 2'b01), 2, 2'b00, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
      pin("pin_rsvd", mk(4, 32'h200, 1, 2, 2'b11), 2, 2'b10, 32'h200, 32'h204, 32'h0, 32'h0);
      pin("pin_size", mk(6, 32'h300, 1, 3, 2'b01), 2, 2'b10, 32'h300, 32'h308, 32'h0, 32'h0);
      pin("pin_badwrap", mk(7, 32'h10, 2, 2, 2'b10), 3, 2'b10, 32'h10, 32'h14, 32'h18, 32'h0);

      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;
      rmode = 0;

      @(posedge ACLK); #2;
      arq.push_back(mk(5, 32'h100, 3, 2, 2'b01));
      wait_idle(200);
      arq.push_back(mk(1, 32'h108, 3, 2, 2'b10));
      arq.push_back(mk(2, 32'h40, 2, 2, 2'b00));
      wait_idle(200);

      low_cnt = 0;
      rmode = 2;
      arq.push_back(mk(8, 32'h800, 3, 2, 2'b01));
      wait_idle(200);
      chk("bp_stall_cycles", 64'(low_cnt), 64'd5);
      rmode = 0;

      pop_log.delete();
      rv_log.delete();
      arq.push_back(mk(10, 32'h20, 0, 2, 2'b01));
      arq.push_back(mk(11, 32'h24, 0, 2, 2'b01));
      wait_idle(200);
      chk("b2b_pops", 64'(pop_log.size()), 64'd2);
      chk("b2b_rvalids", 64'(rv_log.size()), 64'd2);
      if (pop_log.size() >= 2 && rv_log.size() >= 2) begin
         chk("b2b_pop_gap", 64'(pop_log[1] - pop_log[0]), 64'd4);
         chk("b2b_rv1_lat", 64'(rv_log[0] - pop_log[0]), 64'd3);
         chk("b2b_rv2_lat", 64'(rv_log[1] - pop_log[0]), 64'd7);
      end

      rmode = 1;
      arq.push_back(mk(4, 32'h200, 1, 2, 2'b11));
      arq.push_back(mk(6, 32'h300, 1, 3, 2'b01));
      arq.push_back(mk(7, 32'h10, 2, 2, 2'b10));
      wait_idle(300);

      for (int i = 0; i < 40; i++) begin
         ar_t         a;
         logic [31:0] r;
         r = $urandom();
         a.id    = r[3:0];
         a.len   = r[7:4];
         a.size  = {r[16] & r[17] & r[18], r[9:8]};
         a.burst = r[11:10];
         a.addr  = r[13] ? (32'hFFFF_FF00 | {24'd0, r[31:24]}) : $urandom();
         repeat (int'(r[22:20]) + 1) @(posedge ACLK);
         #2;
         arq.push_back(a);
      end
      wait_idle(5000);

      rmode = 3;
      arq.push_back(mk(9, 32'h500, 3, 2, 2'b01));
      arq.push_back(mk(3, 32'hFFFF_FFFC, 1, 2, 2'b01));
      n = 0;
      while (!bus.RVALID && n < 50) begin
         @(posedge ACLK);
         #2;
         n++;
      end
      chk("rst_wait_rvalid", 64'(bus.RVALID), 64'd1);
      @(posedge ACLK);
      #3 ARESET = 1'b1;
      #1;
      chk("async_RVALID", 64'(bus.RVALID), 64'd0);
      chk("async_mem_en", 64'(bus.mem_en), 64'd0);
      chk("async_pop", 64'(bus.pop), 64'd0);
      repeat (2) @(posedge ACLK);
      #1 ARESET = 1'b0;
      rmode = 0;
      wait_idle(200);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
